wb_stage: RTL

Writeback stage of the RV64 pipeline: holds the MEM/WB pipeline register and drives the general-purpose register file's single write port. It selects the writeback source (ALU result, extended load data, or PC+4) and performs RV64 load byte-lane extraction with sign/zero extension. It also maintains a 64-bit retired-instruction counter. Its outputs connect directly to the register file's `we` / `write_num` / `to_write_data` inputs.

---
 rtl/wb_stage.sv | 83 ++++++++
 1 files changed

// File: rtl/wb_stage.sv
// wb_stage: RV64 writeback stage with MEM/WB register, load extraction and retire counter.
// Optional WB_MISALIGN_CHECK_EN flags misaligned loads and suppresses their write/retire.
module wb_stage #(
  parameter int XLEN = 64,
  parameter int REG_FILE_BITS = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     in_reg_we,
  input  logic [REG_FILE_BITS-1:0] in_rd,
  input  logic [1:0]               in_wb_sel,
  input  logic [2:0]               in_funct3,
  input  logic [XLEN-1:0]          in_alu_result,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_mem_rdata,
  output logic                     we,
  output logic [REG_FILE_BITS-1:0] write_num,
  output logic [XLEN-1:0]          to_write_data,
  output logic                     wb_valid,
  output logic                     misalign_exc,
  output logic [63:0]              instret
);
  logic                     valid_q, reg_we_q;
  logic [REG_FILE_BITS-1:0] rd_q;
  logic [1:0]               wb_sel_q;
  logic [2:0]               funct3_q;
  logic [XLEN-1:0]          alu_q, pc_q, rdata_q;
  logic [63:0]              instret_q;
  logic [2:0]               off;
  logic                     sx;
  logic [XLEN-1:0]          lane, load_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q   <= 1'b0;
      reg_we_q  <= 1'b0;
      rd_q      <= '0;
      wb_sel_q  <= '0;
      funct3_q  <= '0;
      alu_q     <= '0;
      pc_q      <= '0;
      rdata_q   <= '0;
      instret_q <= '0;
    end else begin
      if (valid_q && !stall && !misalign_exc) instret_q <= instret_q + 64'd1;
      if (flush) valid_q <= 1'b0;
      else if (!stall) begin
        valid_q  <= in_valid;
        reg_we_q <= in_reg_we;
        rd_q     <= in_rd;
        wb_sel_q <= in_wb_sel;
        funct3_q <= in_funct3;
        alu_q    <= in_alu_result;
        pc_q     <= in_pc;
        rdata_q  <= in_mem_rdata;
      end
    end
  // funct3[1:0] is the access size, funct3[2] selects zero extension
  always_comb begin
    off       = alu_q[2:0];
    sx        = !funct3_q[2];
    lane      = rdata_q >> {off, 3'b000};
    load_data = funct3_q[1:0] == 2'd0 ? {{(XLEN-8){sx & lane[7]}}, lane[7:0]} :
                funct3_q[1:0] == 2'd1 ? {{(XLEN-16){sx & lane[15]}}, lane[15:0]} :
                funct3_q[1:0] == 2'd2 ? {{(XLEN-32){sx & lane[31]}}, lane[31:0]} : lane;
  end
`ifdef WB_MISALIGN_CHECK_EN
  assign misalign_exc = valid_q && wb_sel_q == 2'd1 &&
                        (funct3_q[1:0] == 2'd1 ? off[0] :
                         funct3_q[1:0] == 2'd2 ? |off[1:0] :
                         funct3_q[1:0] == 2'd3 ? |off : 1'b0);
`else
  assign misalign_exc = 1'b0;
`endif
  assign to_write_data = wb_sel_q == 2'd1 ? load_data :
                         wb_sel_q == 2'd2 ? pc_q + XLEN'(4) : alu_q;
  assign we        = valid_q && reg_we_q && rd_q != '0 && !stall && !misalign_exc;
  assign write_num = rd_q;
  assign wb_valid  = valid_q;
  assign instret   = instret_q;
endmodule
